multiplier: RTL and testbench

- Sequential unsigned shift-add multiplier. Multiplies an M-bit multiplicand by an N-bit multiplier, one multiplier bit per clock.
- Returns a full-width M+N-bit product.
- Standalone arithmetic block, started by a level enable and reporting completion with a one-cycle done pulse.

---
 rtl/multiplier_pkg.sv | 16 +
 rtl/multiplier_if.sv | 23 ++
 rtl/multiplier.sv | 75 +++++++
 tb/tb_multiplier.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding
// and the counter-width helper.
package mult_pkg;

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  localparam int M_DEFAULT = 26;
  localparam int N_DEFAULT = 13;

  // Counter must hold values 0..n so the iteration count fits with headroom.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multiplier_if.sv
// Start/operand/result bundle for the multiplier; master drives operands,
// slave (the multiplier) returns product and status.
interface multiplier_if #(
  parameter int M = 26,
  parameter int N = 13
);
  logic         en;
  logic [M-1:0] multi1;
  logic [N-1:0] multi2;
  logic [M+N-1:0] product;
  logic         busy;
  logic         done;

  modport master (
    output en, multi1, multi2,
    input  product, busy, done
  );

  modport slave (
    input  en, multi1, multi2,
    output product, busy, done
  );
endinterface

// File: rtl/multiplier.sv
// Unsigned M x N shift-add multiplier, one multiplier bit per clock with a
// fixed latency of N cycles from the load edge to the done pulse.
//
// state | meaning
// IDLE  | waiting for en; loads operands on the edge where en is high
// BUSY  | N shift-add iterations; returns to IDLE on the last one
module multiplier
  import mult_pkg::*;
#(
  parameter int M = 26,
  parameter int N = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  multiplier_if.slave   bus
);

  localparam int CW = cnt_width(N);
  localparam int PW = M + N;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic          state;
  logic [PW-1:0] mcand;
  logic [PW-1:0] acc;
  logic [N-1:0]  mplier;
  logic [CW-1:0] cnt;
  logic [PW-1:0] product_q;
  logic          done_q;
  logic [PW-1:0] acc_nxt;

  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      cnt       <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en) begin
            mcand  <= {{N{1'b0}}, bus.multi1};
            mplier <= bus.multi2;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Latency is fixed at N even if the remaining multiplier bits are zero.
          if (cnt == CNT_LAST) begin
            product_q <= acc_nxt;
            done_q    <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state == BUSY);

endmodule

// File: tb/tb_multiplier.sv
// Directed and randomized checks for the shift-add multiplier.
module tb_multiplier;
  localparam int M = 26;
  localparam int N = 13;

  typedef struct {
    logic [M-1:0]   a;
    logic [N-1:0]   b;
    logic [M+N-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multiplier_if #(.M(M), .N(N)) bus ();
  multiplier #(.M(M), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns the number of rising edges until done is seen, or -1 on timeout.
  task automatic wait_done(output int lat);
    bit seen;
    seen = 1'b0;
    lat = -1;
    for (int k = 1; k <= N + 3 && !seen; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        seen = 1'b1;
      end
    end
  endtask

  task automatic run_op(input logic [M-1:0] a, input logic [N-1:0] b,
                        output logic [63:0] p, output int lat);
    @(negedge clk);
    bus.multi1 = a;
    bus.multi2 = b;
    bus.en = 1'b1;
    @(posedge clk); #1;
    bus.en = 1'b0;
    wait_done(lat);
    p = 64'(bus.product);
  endtask

  task automatic count_dones(input int ncyc, output int nd, output int nb);
    nd = 0;
    nb = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      if (bus.done) nd++;
      if (bus.busy) nb++;
    end
  endtask

  vec_t        vecs[8];
  logic [63:0] p;
  int          lat, nd, nb, last;
  logic [M-1:0] ra;
  logic [N-1:0] rb;
  logic [63:0] rexp;

  initial begin
    vecs[0] = '{a: 26'h050A01,   b: 13'h1024, exp: 39'd1364555812};
    vecs[1] = '{a: 26'h3FFFFFF,  b: 13'h1FFF, exp: 39'h7FFBFFE001};
    vecs[2] = '{a: 26'h0,        b: 13'h1FFF, exp: 39'h0};
    vecs[3] = '{a: 26'h3FFFFFF,  b: 13'h0,    exp: 39'h0};
    vecs[4] = '{a: 26'd3,        b: 13'd5,    exp: 39'd15};
    vecs[5] = '{a: 26'd1,        b: 13'h1FFF, exp: 39'd8191};
    vecs[6] = '{a: 26'h2000000,  b: 13'h1000, exp: 39'h2000000000};
    vecs[7] = '{a: 26'h3FFFFFF,  b: 13'h1000, exp: 39'h3FFFFFF000};

    // Reset held with en high: nothing starts, outputs at reset values.
    bus.en = 1'b1;
    bus.multi1 = 26'h050A01;
    bus.multi2 = 13'h1024;
    repeat (3) @(negedge clk);
    check("rst_product", 64'(bus.product), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_first_load_busy", 64'(bus.busy), 64'd1);
    wait_done(lat);
    bus.en = 1'b0;
    check("rst_first_latency", 64'(lat), 64'(N));
    check("rst_first_product", 64'(bus.product), 64'd1364555812);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, p, lat);
      check($sformatf("vec%0d_product", i), p, 64'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(N));
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), 64'(bus.done), 64'd0);
      check($sformatf("vec%0d_idle", i), 64'(bus.busy), 64'd0);
    end

    // Operand and en changes during BUSY are ignored.
    @(negedge clk);
    bus.multi1 = 26'd3;
    bus.multi2 = 13'd5;
    bus.en = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    bus.multi1 = 26'd7;
    bus.multi2 = 13'd9;
    bus.en = 1'b0;
    wait_done(lat);
    check("chg_latency", 64'(lat), 64'(N - 4));
    check("chg_product", 64'(bus.product), 64'd15);
    count_dones(20, nd, nb);
    check("chg_no_restart_done", 64'(nd), 64'd0);
    check("chg_no_restart_busy", 64'(nb), 64'd0);
    check("chg_product_held", 64'(bus.product), 64'd15);
    run_op(26'd7, 13'd9, p, lat);
    check("chg_reassert_product", p, 64'd63);

    // Reset in the middle of an operation aborts without a done pulse.
    @(negedge clk);
    bus.multi1 = 26'd100;
    bus.multi2 = 13'd200;
    bus.en = 1'b1;
    @(posedge clk); #1;
    bus.en = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_product", 64'(bus.product), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(20, nd, nb);
    check("midrst_no_done", 64'(nd), 64'd0);
    check("midrst_product_held", 64'(bus.product), 64'd0);
    run_op(26'd123, 13'd456, p, lat);
    check("midrst_fresh_product", p, 64'd56088);
    check("midrst_fresh_latency", 64'(lat), 64'(N));

    // Static inputs with en held: same product rewritten each N+1 cycles.
    @(negedge clk);
    bus.multi1 = 26'h050A01;
    bus.multi2 = 13'h1024;
    bus.en = 1'b1;
    last = -1;
    for (int i = 0; i < 3; i++) begin
      wait_done(lat);
      check($sformatf("static%0d_product", i), 64'(bus.product), 64'd1364555812);
      if (last >= 0) check($sformatf("static%0d_spacing", i), 64'(cyc - last), 64'(N + 1));
      last = cyc;
    end

    // Randomized back-to-back operation under constant en.
    ra = M'($urandom);
    rb = N'($urandom);
    bus.multi1 = ra;
    bus.multi2 = rb;
    rexp = 64'(ra) * 64'(rb);
    last = -1;
    for (int i = 0; i < 1000; i++) begin
      wait_done(lat);
      if (lat < 0) begin
        check("rand_timeout", 64'(lat), 64'(N + 1));
        break;
      end
      check($sformatf("rand%0d_product", i), 64'(bus.product), rexp);
      if (last >= 0) check($sformatf("rand%0d_spacing", i), 64'(cyc - last), 64'(N + 1));
      last = cyc;
      ra = M'($urandom);
      rb = N'($urandom);
      bus.multi1 = ra;
      bus.multi2 = rb;
      rexp = 64'(ra) * 64'(rb);
    end
    bus.en = 1'b0;
    repeat (N + 3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
